// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory read address and
// loads the IF/ID pipeline register. Stall, branch redirect/flush and a
// small run-control FSM (IDLE/RUN/HALT) decide what happens on each edge.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; pc and IF/ID hold their reset values
// S_RUN  | fetching one word per cycle, honouring stall and branches
// S_HALT | stopped; IF/ID bubbled once, then everything holds until reset
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [1:0]  fetch_state,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    // Byte address of the final memory word; fetching it ends the run.
    localparam logic [31:0] LAST_PC = 32'(4 * (IMEM_WORDS - 1));

    state_t      state;
    logic [31:0] pc;
    logic        target_misaligned;
    logic        at_last_word;

    // The memory address comes straight from the pc register, so stall and
    // branch inputs never reach imem_addr combinationally.
    assign imem_addr   = pc;
    assign fetch_state = state;

    // Decode helpers for the RUN-state priority chain.
    assign target_misaligned = (branch_target[1:0] != 2'b00);
    assign at_last_word      = (pc == LAST_PC);

    // Run-control FSM together with the PC and IF/ID registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // halt_req wins over start; nothing else is looked at here
                    if (halt_req) begin
                        state <= S_HALT;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (halt_req) begin
                        if_id_pc    <= pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= S_HALT;
                    end else if (branch_taken && target_misaligned) begin
                        // A misaligned redirect is fatal: keep pc, flag it, stop.
                        if_id_pc    <= pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        fetch_err   <= 1'b1;
                        state       <= S_HALT;
                    end else if (branch_taken) begin
                        // Redirect beats stall; the wrong-path word is flushed.
                        if_id_pc    <= pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        pc          <= branch_target;
                    end else if (!stall) begin
                        if_id_pc    <= pc;
                        if_id_instr <= imem_instr;
                        if_id_valid <= 1'b1;
                        // No wrap-around: the last word is delivered, then we stop.
                        if (at_last_word) begin
                            state <= S_HALT;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end

                S_HALT: begin
                    // Bubble once if a real instruction is still held, then freeze.
                    if (if_id_valid) begin
                        if_id_pc    <= pc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// stimulus, all compared against a rule-level reference model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        halt_req;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  fetch_state;
    logic        fetch_err;

    logic [31:0] mem [64];

    int tests_run;
    int tests_failed;

    // reference model state
    int unsigned m_pc;
    int unsigned m_ipc;
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_state;   // 0 idle, 1 run, 2 halt
    bit          m_err;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(64),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .halt_req     (halt_req),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_instr   (imem_instr),
        .imem_addr    (imem_addr),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .fetch_state  (fetch_state),
        .fetch_err    (fetch_err)
    );

    assign imem_instr = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [99:0] dut_vec();
        return {imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_state, fetch_err};
    endfunction

    function automatic logic [99:0] model_vec();
        return {m_pc, m_ipc, m_instr, m_valid, 2'(m_state), m_err};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_state = 0; m_err = 0;
    endtask

    task automatic model_bubble();
        m_ipc = m_pc; m_instr = NOP; m_valid = 0;
    endtask

    // Apply the rules for one rising edge to the model.
    task automatic model_edge(input bit s, input bit h, input bit st, input bit br,
                              input int unsigned tgt);
        case (m_state)
            0: begin
                if (h) m_state = 2;
                else if (s) m_state = 1;
            end
            1: begin
                if (h) begin
                    model_bubble(); m_state = 2;
                end else if (br && (tgt % 4 != 0)) begin
                    model_bubble(); m_err = 1; m_state = 2;
                end else if (br) begin
                    model_bubble(); m_pc = tgt;
                end else if (!st) begin
                    m_ipc = m_pc; m_instr = mem[(m_pc % 256) / 4]; m_valid = 1;
                    if (m_pc == 252) m_state = 2;
                    else m_pc = m_pc + 4;
                end
            end
            default: begin
                if (m_valid) model_bubble();
            end
        endcase
    endtask

    // Drive inputs at a falling edge, predict the next rising edge, return at
    // the following falling edge where outputs are sampled.
    task automatic step(input bit s, input bit h, input bit st, input bit br,
                        input logic [31:0] tgt);
        start = s; halt_req = h; stall = st; branch_taken = br; branch_target = tgt;
        model_edge(s, h, st, br, tgt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        start = 0; halt_req = 0; stall = 0; branch_taken = 0; branch_target = 0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (dut_vec() !== {32'h0, 32'h0, NOP, 1'b0, 2'b00, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values got=%h exp=%h", dut_vec(),
                     {32'h0, 32'h0, NOP, 1'b0, 2'b00, 1'b0});
        end
        // IDLE ignores stall/branch
        step(0, 0, 1, 1, 32'h40);
        tests_run++;
        if (dut_vec() !== model_vec() || fetch_state !== 2'b00 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL idle_ignores got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        step(1, 0, 0, 0, 0);
        tests_run++;
        if (fetch_state !== 2'b01 || if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_edge state=%b valid=%b pc=%h exp 01/0/0", fetch_state,
                     if_id_valid, imem_addr);
        end
        step(0, 0, 0, 0, 0);
        tests_run++;
        if (if_id_pc !== 32'h0 || if_id_instr !== 32'h00F00093 || if_id_valid !== 1'b1 ||
            imem_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL first_fetch ipc=%h instr=%h valid=%b pc=%h exp 0/00f00093/1/4",
                     if_id_pc, if_id_instr, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_straight_run();
        int bad;
        bad = 0;
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 0, 0, 0);
            if (if_id_pc !== 32'(i * 4) || if_id_instr !== mem[i] || if_id_valid !== 1'b1)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL straight_sequence bad_cycles=%0d required=0", bad);
        end
        tests_run++;
        if (fetch_state !== 2'b10 || imem_addr !== 32'd252) begin
            tests_failed++;
            $display("FAIL last_word_halt state=%b pc=%h exp 10/fc", fetch_state, imem_addr);
        end
        step(1, 0, 0, 0, 0);
        tests_run++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'd252 ||
            imem_addr !== 32'd252 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL halt_bubble got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        tests_run++;
        if (imem_addr !== 32'd12) begin
            tests_failed++;
            $display("FAIL stall_setup pc=%h exp=c", imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            if (imem_addr !== 32'd12 || if_id_pc !== 32'd8 || if_id_instr !== mem[2] ||
                if_id_valid !== 1'b1)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stall_freeze bad_cycles=%0d required=0", bad);
        end
        step(0, 0, 0, 0, 0);
        tests_run++;
        if (if_id_pc !== 32'd12 || if_id_instr !== mem[3] || imem_addr !== 32'd16) begin
            tests_failed++;
            $display("FAIL stall_resume ipc=%h instr=%h pc=%h exp c/%h/10", if_id_pc,
                     if_id_instr, imem_addr, mem[3]);
        end
    endtask

    task automatic test_branch_and_err();
        step(0, 0, 0, 0, 0);   // pc 16 -> 20
        step(0, 0, 1, 1, 32'h2C);
        tests_run++;
        if (imem_addr !== 32'h2C || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
            if_id_pc !== 32'd20) begin
            tests_failed++;
            $display("FAIL branch_flush pc=%h valid=%b instr=%h ipc=%h exp 2c/0/0/14",
                     imem_addr, if_id_valid, if_id_instr, if_id_pc);
        end
        step(0, 0, 0, 0, 0);
        tests_run++;
        if (if_id_pc !== 32'h2C || if_id_valid !== 1'b1 || if_id_instr !== mem[11]) begin
            tests_failed++;
            $display("FAIL branch_target_word ipc=%h valid=%b instr=%h exp 2c/1/%h",
                     if_id_pc, if_id_valid, if_id_instr, mem[11]);
        end
        step(0, 0, 0, 1, 32'h2E);
        tests_run++;
        if (fetch_err !== 1'b1 || fetch_state !== 2'b10 || if_id_valid !== 1'b0 ||
            imem_addr !== 32'h30) begin
            tests_failed++;
            $display("FAIL misaligned err=%b state=%b valid=%b pc=%h exp 1/10/0/30",
                     fetch_err, fetch_state, if_id_valid, imem_addr);
        end
        step(1, 0, 0, 1, 32'h40);
        step(1, 0, 0, 0, 0);
        tests_run++;
        if (dut_vec() !== {32'h30, 32'h30, NOP, 1'b0, 2'b10, 1'b1}) begin
            tests_failed++;
            $display("FAIL halt_sticky got=%h exp=%h", dut_vec(),
                     {32'h30, 32'h30, NOP, 1'b0, 2'b10, 1'b1});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (dut_vec() !== {32'h0, 32'h0, NOP, 1'b0, 2'b00, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(),
                     {32'h0, 32'h0, NOP, 1'b0, 2'b00, 1'b0});
        end
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (fetch_state !== 2'b00 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL after_reset state=%b pc=%h exp 00/0", fetch_state, imem_addr);
        end
        step(0, 1, 0, 0, 0);   // halt_req from IDLE
        tests_run++;
        if (fetch_state !== 2'b10 || if_id_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_halt state=%b valid=%b exp 10/0", fetch_state, if_id_valid);
        end
    endtask

    task automatic test_random();
        int bad;
        bit s, h, st, br;
        logic [31:0] tgt;
        for (int ep = 0; ep < 6; ep++) begin
            bad = 0;
            do_reset();
            for (int c = 0; c < 90; c++) begin
                s   = ($urandom_range(0, 3) == 0);
                h   = ($urandom_range(0, 49) == 0);
                st  = ($urandom_range(0, 4) == 0);
                br  = ($urandom_range(0, 7) == 0);
                tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                step(s, h, st, br, tgt);
                if (dut_vec() !== model_vec()) begin
                    bad++;
                    if (bad == 1)
                        $display("FAIL random_ep%0d cycle=%0d got=%h exp=%h", ep, c,
                                 dut_vec(), model_vec());
                end
            end
            tests_run++;
            if (bad != 0) tests_failed++;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        start = 0; halt_req = 0; stall = 0; branch_taken = 0; branch_target = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00F00093;
        model_reset();

        test_reset();
        test_first_fetch();
        test_straight_run();
        test_stall();
        test_branch_and_err();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
